// File: rtl/tt_chk_pkg.sv
// tt_chk_pkg: shared FSM encoding and sizing for the truth-table response checker
package tt_chk_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam int N_IN_DFLT = 4;
  localparam int N_PAT = 2 ** N_IN_DFLT;
  localparam int CNT_W = 4;
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: counts the cycles a pattern has been held and pulses when it has settled
// ports: clk, rst (async, active high), clear (restart count), enable (count while driving),
//        expired (high in the cycle the count reaches SETTLE-1)
module tt_settle_timer
  import tt_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  assign expired = enable && cnt == CNT_W'(SETTLE - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear || expired) cnt <= '0;
    else if (enable) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/tt_response_checker.sv
// tt_response_checker: sweeps every input pattern into a combinational DUT and checks q against a truth table
// ports: clk, rst (async, active high), start (run a sweep), q (DUT response),
//        pattern (DUT inputs, MSB = a), busy, done, pass (valid while done),
//        captured (bit i = q seen for pattern i), err_cnt (mismatching patterns)
// optional (TT_FIRST_FAIL_EN): first_fail (index of first mismatch), first_fail_vld
module tt_response_checker
  import tt_chk_pkg::*;
#(
  parameter int N_IN = N_IN_DFLT,
  parameter int SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 16'hA5F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              q,
  output logic [N_IN-1:0]   pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N_IN-1:0] captured,
  output logic [N_IN:0]     err_cnt
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]   first_fail,
  output logic              first_fail_vld
`endif
);
  localparam int NP = 2 ** N_IN;
  state_t state;
  logic acc, mis, expired;
  logic [N_IN:0] err_nxt;
  assign acc = start && (state == IDLE || state == DONE);
  assign mis = q != EXPECTED[pattern];
  assign err_nxt = err_cnt + (N_IN + 1)'(mis);
  tt_settle_timer #(.SETTLE(SETTLE)) u_tmr (
    .clk,
    .rst,
    .clear(acc),
    .enable(state == DRIVE),
    .expired
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pattern <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      captured <= '0;
      err_cnt <= '0;
`ifdef TT_FIRST_FAIL_EN
      first_fail <= '0;
      first_fail_vld <= 1'b0;
`endif
    end else
      case (state)
        IDLE, DONE:
          if (acc) begin
            state <= DRIVE;
            pattern <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            captured <= '0;
            err_cnt <= '0;
`ifdef TT_FIRST_FAIL_EN
            first_fail <= '0;
            first_fail_vld <= 1'b0;
`endif
          end
        DRIVE: if (expired) state <= SAMPLE;
        SAMPLE: begin
          captured[pattern] <= q;
          err_cnt <= err_nxt;
`ifdef TT_FIRST_FAIL_EN
          if (mis && !first_fail_vld) begin
            first_fail <= pattern;
            first_fail_vld <= 1'b1;
          end
`endif
          if (pattern == N_IN'(NP - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_nxt == '0;
          end else begin
            pattern <= pattern + N_IN'(1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_tt_response_checker.sv
// tb_tt_response_checker: randomized scoreboard bench for the truth-table response checker
module tb_tt_response_checker;
  import tt_chk_pkg::*;
  localparam logic [15:0] EXP = 16'hA5F0;
  typedef struct {
    logic [15:0] cap;
    int err;
    logic pass;
    int lat;
    int ff;
    logic ffv;
  } exp_t;
  logic clk = 0, rst = 1, start0 = 0, start1 = 0;
  logic [15:0] mask0 = '0, mask1 = '0;
  logic dly0 = 0;
  logic [3:0] pat0, pat1, d1_0, d2_0, d1_1, d2_1;
  logic busy0, done0, pass0, busy1, done1, pass1, q0, q1;
  logic [15:0] cap0, cap1;
  logic [4:0] err0, err1;
  logic [3:0] ff0, ff1;
  logic ffv0, ffv1;
  int errors = 0, checks = 0, bc0 = 0, bc1 = 0;
  logic dq0 = 0, dq1 = 0;
  exp_t q0s[$], q1s[$];
  always #5 clk = ~clk;
  // DUT models: q = (EXP ^ mask) evaluated at the current pattern, or at the pattern two cycles ago
  always @(posedge clk) begin
    d1_0 <= pat0;
    d2_0 <= d1_0;
    d1_1 <= pat1;
    d2_1 <= d1_1;
  end
  assign q0 = (EXP ^ mask0) >> (dly0 ? d2_0 : pat0);
  assign q1 = (EXP ^ mask1) >> d2_1;
  tt_response_checker #(.N_IN(4), .SETTLE(2), .EXPECTED(EXP)) u0 (
    .clk(clk), .rst(rst), .start(start0), .q(q0), .pattern(pat0), .busy(busy0),
    .done(done0), .pass(pass0), .captured(cap0), .err_cnt(err0)
`ifdef TT_FIRST_FAIL_EN
    , .first_fail(ff0), .first_fail_vld(ffv0)
`endif
  );
  tt_response_checker #(.N_IN(4), .SETTLE(1), .EXPECTED(EXP)) u1 (
    .clk(clk), .rst(rst), .start(start1), .q(q1), .pattern(pat1), .busy(busy1),
    .done(done1), .pass(pass1), .captured(cap1), .err_cnt(err1)
`ifdef TT_FIRST_FAIL_EN
    , .first_fail(ff1), .first_fail_vld(ffv1)
`endif
  );
`ifndef TT_FIRST_FAIL_EN
  assign ff0 = '0;
  assign ff1 = '0;
  assign ffv0 = 1'b0;
  assign ffv1 = 1'b0;
`endif
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Pattern p is held for s+1 cycles and sampled in the last; a d-cycle-late DUT therefore
  // shows the pattern driven d cycles before that, or the pre-start pattern if none.
  function automatic exp_t model(int s, int d, logic [15:0] mask, int prev);
    exp_t e;
    logic [15:0] g = EXP ^ mask;
    int src;
    e.cap = '0;
    for (int p = 0; p < N_PAT; p++) begin
      src = p * (s + 1) + s - d;
      e.cap[p] = g[src < 0 ? prev : src / (s + 1)];
    end
    e.err = $countones(e.cap ^ EXP);
    e.pass = e.err == 0;
    e.lat = N_PAT * (s + 1);
    e.ffv = e.err != 0;
    e.ff = 0;
    for (int p = N_PAT - 1; p >= 0; p--) if (e.cap[p] != EXP[p]) e.ff = p;
    return e;
  endfunction
  task automatic cmp(string t, exp_t e, logic [15:0] cap, logic [4:0] err, logic pass, int bc,
                     logic [3:0] ff, logic ffv);
    check({t, "_captured"}, cap, e.cap);
    check({t, "_err_cnt"}, err, e.err);
    check({t, "_pass"}, pass, e.pass);
    check({t, "_latency"}, bc, e.lat);
`ifdef TT_FIRST_FAIL_EN
    check({t, "_first_fail_vld"}, ffv, e.ffv);
    if (e.ffv) check({t, "_first_fail"}, ff, e.ff);
`else
    if (ffv) check({t, "_ff_absent"}, ff, 0);
`endif
  endtask
  always @(negedge clk) begin
    if (rst) begin
      bc0 = 0;
      dq0 = 0;
    end else begin
      if (busy0) bc0++;
      if (done0 && !dq0) begin
        if (q0s.size() == 0) check("u0_unexpected_done", 1, 0);
        else cmp("u0", q0s.pop_front(), cap0, err0, pass0, bc0, ff0, ffv0);
        bc0 = 0;
      end
      dq0 = done0;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      bc1 = 0;
      dq1 = 0;
    end else begin
      if (busy1) bc1++;
      if (done1 && !dq1) begin
        if (q1s.size() == 0) check("u1_unexpected_done", 1, 0);
        else cmp("u1", q1s.pop_front(), cap1, err1, pass1, bc1, ff1, ffv1);
        bc1 = 0;
      end
      dq1 = done1;
    end
  end
  task automatic launch0(logic [15:0] mask, logic dly);
    @(negedge clk);
    mask0 = mask;
    dly0 = dly;
    q0s.push_back(model(2, dly ? 2 : 0, mask, int'(pat0)));
    start0 = 1;
    @(negedge clk);
    start0 = 0;
  endtask
  task automatic wait_done0();
    for (int i = 0; i < 300 && !done0; i++) @(negedge clk);
    check("u0_done_timeout", done0, 1);
  endtask
  task automatic run0(logic [15:0] mask, logic dly, int mid);
    launch0(mask, dly);
    if (mid >= 0) begin
      for (int i = 0; i < 300 && int'(pat0) != mid; i++) @(negedge clk);
      start0 = 1;
      @(negedge clk);
      start0 = 0;
    end
    wait_done0();
  endtask
  task automatic run1(logic [15:0] mask);
    @(negedge clk);
    mask1 = mask;
    q1s.push_back(model(1, 2, mask, int'(pat1)));
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    for (int i = 0; i < 300 && !done1; i++) @(negedge clk);
    check("u1_done_timeout", done1, 1);
  endtask
  initial begin
    #3;
    check("rst_pattern", pat0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_captured", cap0, 0);
    check("rst_err_cnt", err0, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    run0(16'h0000, 0, -1);
    run0(16'h0020, 0, -1);
    run0(EXP, 0, -1);
    run0(16'h0000, 0, 7);
    run0(16'h0000, 1, -1);
    launch0(16'h0000, 0);
    for (int i = 0; i < 300 && pat0 != 4'd9; i++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("abort_pattern", pat0, 0);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_pass", pass0, 0);
    check("abort_captured", cap0, 0);
    check("abort_err_cnt", err0, 0);
`ifdef TT_FIRST_FAIL_EN
    check("abort_first_fail_vld", ffv0, 0);
`endif
    q0s.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    run0(16'h0000, 0, -1);
    run1(16'h0000);
    run1(16'($urandom));
    for (int k = 0; k < 4; k++) run0(16'($urandom), 1'($urandom_range(0, 1)), -1);
    repeat (4) @(negedge clk);
    check("u0_queue_drained", q0s.size(), 0);
    check("u1_queue_drained", q1s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
